// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - CPU/DMA request ports and memory port bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          cpu_stall;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic [DW-1:0] dma_rdata;
    logic          dma_ack;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter of CPU and DMA onto one fixed-latency memory port
module mem_port_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int            CW       = 3;
    localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LAT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last_owner;
    logic          owner_q;
    logic          cpu_ack_q;
    logic          dma_ack_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dma_rdata_q;

    logic          any_req;
    logic          grant_dma;
    logic          issue;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic          owner_we;

    always_comb begin
        any_req   = bus.cpu_req | bus.dma_req;
        // On contention the port that did not win last time takes the grant.
        grant_dma = bus.dma_req & (~bus.cpu_req | ~last_owner);
        // Reset gates the strobe directly so a held request cannot reach memory.
        issue     = reset & (state == IDLE) & any_req;
        win_we    = grant_dma ? bus.dma_we    : bus.cpu_we;
        win_addr  = grant_dma ? bus.dma_addr  : bus.cpu_addr;
        win_wdata = grant_dma ? bus.dma_wdata : bus.cpu_wdata;
        owner_we  = owner_q   ? bus.dma_we    : bus.cpu_we;
    end

    assign bus.mem_en    = issue;
    assign bus.mem_we    = issue & win_we;
    assign bus.mem_addr  = issue ? win_addr  : '0;
    assign bus.mem_wdata = issue ? win_wdata : '0;

    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dma_ack   = dma_ack_q;
    assign bus.owner     = owner_q;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            last_owner  <= 1'b1;
            owner_q     <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cpu_ack_q <= 1'b0;
                    dma_ack_q <= 1'b0;
                    if (any_req) begin
                        owner_q    <= grant_dma;
                        last_owner <= grant_dma;
                        cnt        <= LAT_LOAD;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        // Requesters hold we until ack, so the owner's we still describes this access.
                        if (!owner_we) begin
                            if (owner_q) dma_rdata_q <= bus.mem_rdata;
                            else         cpu_rdata_q <= bus.mem_rdata;
                        end
                        cpu_ack_q <= ~owner_q;
                        dma_ack_q <= owner_q;
                        state     <= ACK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK: begin
                    cpu_ack_q <= 1'b0;
                    dma_ack_q <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    cpu_ack_q <= 1'b0;
                    dma_ack_q <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(8), .DW(8)) bus  ();
    mem_port_arbiter_if #(.AW(8), .DW(8)) bus1 ();
    mem_port_arbiter_if #(.AW(8), .DW(8)) bus4 ();

    mem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(2)) dut  (.clk(clk), .reset(reset), .bus(bus));
    mem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    mem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    // Byte memory with 2-cycle read latency; 8'hEE marks a cycle where no read data is valid.
    logic [7:0] mem [256];
    logic [7:0] p2_d [2];
    logic       p2_v [2];
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
            mem[8'h10] <= 8'hA5;
        end else if (bus.mem_en && bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
        p2_v[0] <= bus.mem_en & ~bus.mem_we;
        p2_d[0] <= mem[bus.mem_addr];
        p2_v[1] <= p2_v[0];
        p2_d[1] <= p2_d[0];
    end
    assign bus.mem_rdata = p2_v[1] ? p2_d[1] : 8'hEE;

    logic [7:0] p1_d;
    logic       p1_v;
    always @(posedge clk) begin
        p1_v <= bus1.mem_en & ~bus1.mem_we;
        p1_d <= bus1.mem_addr ^ 8'h5A;
    end
    assign bus1.mem_rdata = p1_v ? p1_d : 8'hEE;

    logic [7:0] p4_d [4];
    logic       p4_v [4];
    always @(posedge clk) begin
        p4_v[0] <= bus4.mem_en & ~bus4.mem_we;
        p4_d[0] <= bus4.mem_addr ^ 8'h5A;
        for (int i = 1; i < 4; i++) begin
            p4_v[i] <= p4_v[i-1];
            p4_d[i] <= p4_d[i-1];
        end
    end
    assign bus4.mem_rdata = p4_v[3] ? p4_d[3] : 8'hEE;

    function automatic logic [7:0] pat(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    task automatic idle_inputs();
        bus.cpu_req = 0;  bus.cpu_we = 0;  bus.cpu_addr = 0;  bus.cpu_wdata = 0;
        bus.dma_req = 0;  bus.dma_we = 0;  bus.dma_addr = 0;  bus.dma_wdata = 0;
        bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_addr = 0; bus1.cpu_wdata = 0;
        bus1.dma_req = 0; bus1.dma_we = 0; bus1.dma_addr = 0; bus1.dma_wdata = 0;
        bus4.cpu_req = 0; bus4.cpu_we = 0; bus4.cpu_addr = 0; bus4.cpu_wdata = 0;
        bus4.dma_req = 0; bus4.dma_we = 0; bus4.dma_addr = 0; bus4.dma_wdata = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.cpu_req = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.mem_en !== 1'b0) begin failures++; $display("FAIL rst_mem_en got=%b exp=0", bus.mem_en); end
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
        checks++; if (bus.cpu_ack !== 1'b0) begin failures++; $display("FAIL rst_cpu_ack got=%b exp=0", bus.cpu_ack); end
        checks++; if (bus.dma_ack !== 1'b0) begin failures++; $display("FAIL rst_dma_ack got=%b exp=0", bus.dma_ack); end
        checks++; if (bus.owner !== 1'b0) begin failures++; $display("FAIL rst_owner got=%b exp=0", bus.owner); end
        checks++; if (bus.cpu_rdata !== 8'h00) begin failures++; $display("FAIL rst_cpu_rdata got=%h exp=00", bus.cpu_rdata); end
        checks++; if (bus.dma_rdata !== 8'h00) begin failures++; $display("FAIL rst_dma_rdata got=%h exp=00", bus.dma_rdata); end
        checks++; if (bus.cpu_stall !== 1'b1) begin failures++; $display("FAIL rst_cpu_stall got=%b exp=1", bus.cpu_stall); end
        bus.cpu_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_cpu_read();
        @(posedge clk); #1;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'h10;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (bus.mem_en !== (c == 0)) begin failures++; $display("FAIL rd_mem_en c=%0d got=%b", c, bus.mem_en); end
            if (c == 0) begin
                checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL rd_mem_we got=%b exp=0", bus.mem_we); end
                checks++; if (bus.mem_addr !== 8'h10) begin failures++; $display("FAIL rd_mem_addr got=%h exp=10", bus.mem_addr); end
            end
            checks++; if (bus.cpu_ack !== (c == 3)) begin failures++; $display("FAIL rd_cpu_ack c=%0d got=%b", c, bus.cpu_ack); end
            checks++; if (bus.cpu_stall !== (c < 3)) begin failures++; $display("FAIL rd_cpu_stall c=%0d got=%b", c, bus.cpu_stall); end
            if (c == 3) begin
                checks++; if (bus.cpu_rdata !== 8'hA5) begin failures++; $display("FAIL rd_cpu_rdata got=%h exp=a5", bus.cpu_rdata); end
                bus.cpu_req = 0;
            end
        end
    endtask

    task automatic test_tie_after_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'h20;
        bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 8'h21;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            checks++; if (bus.mem_en !== (c == 0 || c == 4)) begin failures++; $display("FAIL tie_mem_en c=%0d got=%b", c, bus.mem_en); end
            if (c == 0) begin
                checks++; if (bus.mem_addr !== 8'h20) begin failures++; $display("FAIL tie_addr_cpu got=%h exp=20", bus.mem_addr); end
            end
            if (c == 4) begin
                checks++; if (bus.mem_addr !== 8'h21) begin failures++; $display("FAIL tie_addr_dma got=%h exp=21", bus.mem_addr); end
            end
            checks++; if (bus.owner !== (c >= 5)) begin failures++; $display("FAIL tie_owner c=%0d got=%b", c, bus.owner); end
            checks++; if (bus.cpu_ack !== (c == 3)) begin failures++; $display("FAIL tie_cpu_ack c=%0d got=%b", c, bus.cpu_ack); end
            checks++; if (bus.dma_ack !== (c == 7)) begin failures++; $display("FAIL tie_dma_ack c=%0d got=%b", c, bus.dma_ack); end
            if (c == 3) begin
                checks++; if (bus.cpu_rdata !== pat(8'h20)) begin failures++; $display("FAIL tie_cpu_rdata got=%h exp=%h", bus.cpu_rdata, pat(8'h20)); end
                bus.cpu_req = 0;
            end
            if (c == 7) begin
                checks++; if (bus.dma_rdata !== pat(8'h21)) begin failures++; $display("FAIL tie_dma_rdata got=%h exp=%h", bus.dma_rdata, pat(8'h21)); end
                bus.dma_req = 0;
            end
        end
    endtask

    task automatic test_round_robin();
        int grants = 0;
        int last_issue = -1;
        bit done = 0;
        logic [7:0] exp_addr;
        @(posedge clk); #1;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'h30;
        bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 8'h31;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (bus.mem_en) begin
                exp_addr = (grants % 2 == 0) ? 8'h30 : 8'h31;
                checks++; if (bus.mem_addr !== exp_addr) begin failures++; $display("FAIL rr_grant n=%0d got=%h exp=%h", grants, bus.mem_addr, exp_addr); end
                if (grants > 0) begin
                    checks++; if (c - last_issue != 4) begin failures++; $display("FAIL rr_spacing n=%0d got=%0d exp=4", grants, c - last_issue); end
                end
                last_issue = c;
                grants++;
            end
            if (bus.dma_ack && grants == 6) begin
                bus.cpu_req = 0;
                bus.dma_req = 0;
                done = 1;
            end
        end
        checks++; if (!done || grants != 6) begin failures++; $display("FAIL rr_count got=%0d exp=6 done=%0b", grants, done); end
        checks++; if (bus.cpu_rdata !== pat(8'h30)) begin failures++; $display("FAIL rr_cpu_rdata got=%h exp=%h", bus.cpu_rdata, pat(8'h30)); end
        checks++; if (bus.dma_rdata !== pat(8'h31)) begin failures++; $display("FAIL rr_dma_rdata got=%h exp=%h", bus.dma_rdata, pat(8'h31)); end
    endtask

    task automatic test_dma_write();
        logic [7:0] exp_a;
        logic [7:0] exp_d;
        @(posedge clk); #1;
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 8'h3C; bus.dma_wdata = 8'h5E;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            exp_a = (c == 0) ? 8'h3C : 8'h00;
            exp_d = (c == 0) ? 8'h5E : 8'h00;
            checks++; if (bus.mem_en !== (c == 0)) begin failures++; $display("FAIL wr_mem_en c=%0d got=%b", c, bus.mem_en); end
            checks++; if (bus.mem_we !== (c == 0)) begin failures++; $display("FAIL wr_mem_we c=%0d got=%b", c, bus.mem_we); end
            checks++; if (bus.mem_addr !== exp_a) begin failures++; $display("FAIL wr_mem_addr c=%0d got=%h exp=%h", c, bus.mem_addr, exp_a); end
            checks++; if (bus.mem_wdata !== exp_d) begin failures++; $display("FAIL wr_mem_wdata c=%0d got=%h exp=%h", c, bus.mem_wdata, exp_d); end
            checks++; if (bus.dma_ack !== (c == 3)) begin failures++; $display("FAIL wr_dma_ack c=%0d got=%b", c, bus.dma_ack); end
            if (c == 3) begin
                checks++; if (bus.cpu_rdata !== pat(8'h30)) begin failures++; $display("FAIL wr_cpu_rdata got=%h exp=%h", bus.cpu_rdata, pat(8'h30)); end
                checks++; if (bus.dma_rdata !== pat(8'h31)) begin failures++; $display("FAIL wr_dma_rdata got=%h exp=%h", bus.dma_rdata, pat(8'h31)); end
                bus.dma_req = 0; bus.dma_we = 0; bus.dma_wdata = 0;
            end
        end
        checks++; if (mem[8'h3C] !== 8'h5E) begin failures++; $display("FAIL wr_mem_content got=%h exp=5e", mem[8'h3C]); end
    endtask

    task automatic test_reset_mid_access();
        @(posedge clk); #1;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'h44;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++; if (bus.mem_en !== 1'b0) begin failures++; $display("FAIL mid_mem_en got=%b exp=0", bus.mem_en); end
        checks++; if (bus.cpu_ack !== 1'b0) begin failures++; $display("FAIL mid_cpu_ack got=%b exp=0", bus.cpu_ack); end
        checks++; if (bus.dma_ack !== 1'b0) begin failures++; $display("FAIL mid_dma_ack got=%b exp=0", bus.dma_ack); end
        checks++; if (bus.cpu_rdata !== 8'h00) begin failures++; $display("FAIL mid_cpu_rdata got=%h exp=00", bus.cpu_rdata); end
        checks++; if (bus.dma_rdata !== 8'h00) begin failures++; $display("FAIL mid_dma_rdata got=%h exp=00", bus.dma_rdata); end
        checks++; if (bus.owner !== 1'b0) begin failures++; $display("FAIL mid_owner got=%b exp=0", bus.owner); end
        bus.cpu_req = 0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (bus.cpu_ack !== 1'b0 || bus.mem_en !== 1'b0) begin failures++; $display("FAIL mid_quiet c=%0d ack=%b en=%b exp=0", c, bus.cpu_ack, bus.mem_en); end
        end
        @(posedge clk); #1;
        bus.cpu_req = 1; bus.cpu_addr = 8'h44;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (bus.cpu_ack !== (c == 3)) begin failures++; $display("FAIL mid_reissue_ack c=%0d got=%b", c, bus.cpu_ack); end
            if (c == 3) begin
                checks++; if (bus.cpu_rdata !== pat(8'h44)) begin failures++; $display("FAIL mid_reissue_rdata got=%h exp=%h", bus.cpu_rdata, pat(8'h44)); end
                bus.cpu_req = 0;
            end
        end
    endtask

    task automatic test_latency();
        @(posedge clk); #1;
        bus1.cpu_req = 1; bus1.cpu_addr = 8'h55;
        bus4.cpu_req = 1; bus4.cpu_addr = 8'h66;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            checks++; if (bus1.mem_en !== (c == 0)) begin failures++; $display("FAIL lat1_mem_en c=%0d got=%b", c, bus1.mem_en); end
            checks++; if (bus4.mem_en !== (c == 0)) begin failures++; $display("FAIL lat4_mem_en c=%0d got=%b", c, bus4.mem_en); end
            checks++; if (bus1.cpu_ack !== (c == 2)) begin failures++; $display("FAIL lat1_ack c=%0d got=%b", c, bus1.cpu_ack); end
            checks++; if (bus4.cpu_ack !== (c == 5)) begin failures++; $display("FAIL lat4_ack c=%0d got=%b", c, bus4.cpu_ack); end
            checks++; if (bus1.cpu_stall !== (c < 2)) begin failures++; $display("FAIL lat1_stall c=%0d got=%b", c, bus1.cpu_stall); end
            checks++; if (bus4.cpu_stall !== (c < 5)) begin failures++; $display("FAIL lat4_stall c=%0d got=%b", c, bus4.cpu_stall); end
            checks++; if (bus1.dma_ack !== 1'b0 || bus4.dma_ack !== 1'b0) begin failures++; $display("FAIL lat_dma_ack c=%0d got=%b%b exp=00", c, bus1.dma_ack, bus4.dma_ack); end
            checks++; if (bus1.owner !== 1'b0 || bus4.owner !== 1'b0) begin failures++; $display("FAIL lat_owner c=%0d got=%b%b exp=00", c, bus1.owner, bus4.owner); end
            checks++; if (bus1.dma_rdata !== 8'h00 || bus4.dma_rdata !== 8'h00) begin failures++; $display("FAIL lat_dma_rdata c=%0d got=%h/%h exp=00", c, bus1.dma_rdata, bus4.dma_rdata); end
            if (c == 0) begin
                checks++; if (bus1.mem_we !== 1'b0 || bus4.mem_we !== 1'b0) begin failures++; $display("FAIL lat_mem_we got=%b%b exp=00", bus1.mem_we, bus4.mem_we); end
                checks++; if (bus1.mem_wdata !== 8'h00 || bus4.mem_wdata !== 8'h00) begin failures++; $display("FAIL lat_mem_wdata got=%h/%h exp=00", bus1.mem_wdata, bus4.mem_wdata); end
            end
            if (c == 2) begin
                checks++; if (bus1.cpu_rdata !== pat(8'h55)) begin failures++; $display("FAIL lat1_rdata got=%h exp=%h", bus1.cpu_rdata, pat(8'h55)); end
                bus1.cpu_req = 0;
            end
            if (c == 5) begin
                checks++; if (bus4.cpu_rdata !== pat(8'h66)) begin failures++; $display("FAIL lat4_rdata got=%h exp=%h", bus4.cpu_rdata, pat(8'h66)); end
                bus4.cpu_req = 0;
            end
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_cpu_read();
        test_tie_after_reset();
        test_round_robin();
        test_dma_write();
        test_reset_mid_access();
        test_latency();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single shared memory port between the multicycle CPU controller (fetch, load, store) and a DMA/loader requester. Sequences each access through issue, latency wait and acknowledge, applies round-robin fairness under contention, and produces a stall signal that freezes the CPU control FSM until its access completes. Sits between the CPU datapath's memory address/data mux and the byte-wide synchronous memory.

## Interface
- AW, 8, address width in bits
- DW, 8, data width in bits
- MEM_LAT, 2, cycles from mem_en issue to mem_rdata valid; legal range 1..4

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  registered read data for the CPU
- cpu_ack  out  1  one-cycle completion pulse to the CPU
- cpu_stall  out  1  cpu_req & ~cpu_ack; freezes the CPU controller state
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/AW/DW  DMA request, same rules as CPU
- dma_rdata  out  DW  registered read data for DMA
- dma_ack  out  1  one-cycle completion pulse to DMA
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable, only with mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en
- owner  out  1  current/last grant: 0 = CPU, 1 = DMA

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE: no request -> stay. One or more requests -> select winner, assert mem_en for this cycle, drive mem_we/mem_addr/mem_wdata combinationally from winner, latch owner, load latency counter with MEM_LAT-1, go to WAIT.
- Arbitration: single requester wins immediately. Both requesting: winner is the port that is NOT last_owner. last_owner updates on every grant; it resets to DMA so the CPU wins the first tie.
- WAIT: counter decrements each cycle; on the cycle counter = 0, capture mem_rdata into owner's rdata register (reads only; writes leave rdata unchanged), go to ACK.
- ACK: pulse owner's ack for exactly one cycle; go to IDLE. Requests are not sampled in ACK.
- Requests are sampled only in IDLE. A request still high in the cycle after ack is a new access.
- The requester must hold req, we, addr and wdata stable from assertion until ack. The arbiter does not register addr/wdata; memory samples them in the issue cycle.
- Non-owner rdata holds its previous value across other accesses.
- mem_we, mem_addr and mem_wdata are 0 whenever mem_en is 0.
- Reset (reset = 0) acts immediately and asynchronously: state IDLE, counter 0, last_owner DMA, owner 0, cpu_rdata and dma_rdata 0, both acks 0, mem_en/mem_we 0 combinationally, even mid-access. An in-flight access is abandoned with no ack; requesters reissue after reset release.

## Timing
- Access issued in cycle T (IDLE, mem_en = 1). WAIT occupies T+1..T+MEM_LAT. rdata is captured at the end of T+MEM_LAT. ack is high in T+MEM_LAT+1, with rdata already valid in that cycle.
- Access latency from req seen in IDLE to ack: MEM_LAT+1 cycles. Minimum spacing between issues: MEM_LAT+2 cycles.
- cpu_stall is combinational: high from the first cycle of cpu_req through the cycle before cpu_ack; low in the ack cycle.
- Writes take the same latency as reads.
- owner changes only on the clock edge leaving IDLE with a grant.

## Test plan
- CPU read, MEM_LAT=2, memory[0x10]=0xA5, cpu_req at cycle 0 -> mem_en=1/mem_we=0/mem_addr=0x10 at cycle 0 only; cpu_ack at cycle 3 for one cycle; cpu_rdata=0xA5; cpu_stall high cycles 0-2, low at cycle 3.
- Both requests asserted in the first cycle after reset -> CPU issued at cycle 0 with owner=0; DMA issued at cycle 4 with owner=1; dma_ack at cycle 7.
- Both requesters continuously re-requesting for 6 accesses -> grants alternate CPU, DMA, CPU, DMA, CPU, DMA; no port is granted twice in a row.
- DMA write addr 0x3C, data 0x5E -> one cycle of mem_en=mem_we=1 with addr 0x3C and data 0x5E; dma_ack after MEM_LAT+1 cycles; cpu_rdata and dma_rdata unchanged.
- reset pulled low during WAIT of a CPU read -> mem_en, acks, rdata and owner go to 0 immediately; no ack after release; a reissued read completes normally.
- MEM_LAT=1 and MEM_LAT=4 builds -> ack at issue+2 and issue+5 respectively, with data captured from the correct cycle.
